// File: rtl/painterengine_gpu_rotate_ctrl.sv
// Quad-corner job sequencer around a free-running 22-cycle CORDIC rotator.
// Optional bounding-box outputs: PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN.

// CORDIC rotator: x/y signed 16.16, angle in degrees 16.16 (|angle| <= 270).
// Latency is 1 range-fold stage + 20 micro-rotations + 1 gain stage = 22.
module painterengine_gpu_rotate (
   input  logic        i_wire_clock,
   input  logic [31:0] i_wire_x,
   input  logic [31:0] i_wire_y,
   input  logic [31:0] i_wire_angle,
   output logic [31:0] o_wire_x,
   output logic [31:0] o_wire_y
);
   localparam int ITER = 20;
   localparam int W    = 34;
   localparam logic signed [31:0] DEG90  = 32'sd5898240;
   localparam logic signed [31:0] DEG180 = 32'sd11796480;
   localparam logic signed [24:0] GAIN   = 25'sd10188013;

   logic signed [W-1:0]  x_q [ITER+1];
   logic signed [W-1:0]  x_d [ITER+1];
   logic signed [W-1:0]  y_q [ITER+1];
   logic signed [W-1:0]  y_d [ITER+1];
   logic signed [31:0]   z_q [ITER+1];
   logic signed [31:0]   z_d [ITER+1];
   logic signed [W-1:0]  xin, yin;
   logic signed [31:0]   ang;
   logic signed [58:0]   px, py;
   logic        [31:0]   ox_q, ox_d, oy_q, oy_d;

   function automatic logic signed [31:0] atan_deg(input int i);
      case (i)
         0:  return 32'sd2949120;
         1:  return 32'sd1740967;
         2:  return 32'sd919879;
         3:  return 32'sd466945;
         4:  return 32'sd234380;
         5:  return 32'sd117304;
         6:  return 32'sd58666;
         7:  return 32'sd29335;
         8:  return 32'sd14668;
         9:  return 32'sd7334;
         10: return 32'sd3667;
         11: return 32'sd1833;
         12: return 32'sd917;
         13: return 32'sd458;
         14: return 32'sd229;
         15: return 32'sd115;
         16: return 32'sd57;
         17: return 32'sd29;
         18: return 32'sd14;
         19: return 32'sd7;
         default: return 32'sd0;
      endcase
   endfunction

   // Fold angles beyond +-90 deg by a half turn so the CORDIC range covers them.
   always_comb begin
      xin = {{2{i_wire_x[31]}}, i_wire_x};
      yin = {{2{i_wire_y[31]}}, i_wire_y};
      ang = i_wire_angle;
      x_d[0] = xin;
      y_d[0] = yin;
      z_d[0] = ang;
      if (ang > DEG90) begin
         x_d[0] = -xin;
         y_d[0] = -yin;
         z_d[0] = ang - DEG180;
      end else if (ang < -DEG90) begin
         x_d[0] = -xin;
         y_d[0] = -yin;
         z_d[0] = ang + DEG180;
      end
      for (int i = 0; i < ITER; i++) begin
         if (!z_q[i][31]) begin
            x_d[i+1] = x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            z_d[i+1] = z_q[i] - atan_deg(i);
         end else begin
            x_d[i+1] = x_q[i] + (y_q[i] >>> i);
            y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            z_d[i+1] = z_q[i] + atan_deg(i);
         end
      end
      px   = 59'(x_q[ITER]) * 59'(GAIN);
      py   = 59'(y_q[ITER]) * 59'(GAIN);
      ox_d = px[55:24];
      oy_d = py[55:24];
   end

   always_ff @(posedge i_wire_clock) begin
      x_q  <= x_d;
      y_q  <= y_d;
      z_q  <= z_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
   end

   assign o_wire_x = ox_q;
   assign o_wire_y = oy_q;
endmodule

module painterengine_gpu_rotate_ctrl #(
   parameter int ROTATE_LATENCY = 22,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_reset,
   input  logic        i_wire_job_valid,
   output logic        o_wire_job_ready,
   input  logic [31:0] i_wire_cx,
   input  logic [31:0] i_wire_cy,
   input  logic [31:0] i_wire_hw,
   input  logic [31:0] i_wire_hh,
   input  logic [31:0] i_wire_angle,
   output logic        o_wire_point_valid,
   input  logic        i_wire_point_ready,
   output logic [31:0] o_wire_point_x,
   output logic [31:0] o_wire_point_y,
   output logic [1:0]  o_wire_point_idx,
   output logic        o_wire_point_last,
   output logic        o_wire_done
`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
   ,
   output logic [31:0] o_wire_bbox_xmin,
   output logic [31:0] o_wire_bbox_ymin,
   output logic [31:0] o_wire_bbox_xmax,
   output logic [31:0] o_wire_bbox_ymax
`endif
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  idx;
   } entry_t;

   state_t              state_q, state_d;
   logic [31:0]         cx_q, cx_d, cy_q, cy_d, hw_q, hw_d, hh_q, hh_d, ang_q, ang_d;
   logic [1:0]          k_q, k_d;
   logic [ROTATE_LATENCY-1:0] tag_v_q, tag_v_d;
   logic [1:0]          tag_idx_q [ROTATE_LATENCY];
   logic [1:0]          tag_idx_d [ROTATE_LATENCY];
   logic [CW-1:0]       inflight_q, inflight_d, count_q, count_d;
   logic                sum_v_q, sum_v_d;
   entry_t              sum_q, sum_d, head;
   entry_t              mem_q [FIFO_DEPTH];
   entry_t              mem_d [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW:0]         used;
   logic                issue, push, pop;
   logic [31:0]         rot_x_in, rot_y_in, rot_x, rot_y;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   painterengine_gpu_rotate u_rotate (
      .i_wire_clock (i_wire_clock),
      .i_wire_x     (rot_x_in),
      .i_wire_y     (rot_y_in),
      .i_wire_angle (ang_q),
      .o_wire_x     (rot_x),
      .o_wire_y     (rot_y)
   );

   assign head               = mem_q[rd_ptr_q];
   assign o_wire_point_valid = (count_q != '0);
   assign pop                = o_wire_point_valid && i_wire_point_ready;
   assign push               = sum_v_q;
   // Inflight spans both the tag pipe and the sum register, so credit never over-promises.
   assign used               = (CW+1)'(count_q) + (CW+1)'(inflight_q);

   always_comb begin
      state_d = state_q;
      cx_d = cx_q; cy_d = cy_q; hw_d = hw_q; hh_d = hh_q; ang_d = ang_q;
      k_d = k_q;
      issue = 1'b0;
      o_wire_job_ready = 1'b0;
      o_wire_done = 1'b0;
      case (state_q)
         IDLE: begin
            o_wire_job_ready = 1'b1;
            if (i_wire_job_valid) begin
               cx_d = i_wire_cx; cy_d = i_wire_cy;
               hw_d = i_wire_hw; hh_d = i_wire_hh;
               ang_d = i_wire_angle;
               k_d = 2'd0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (used < (CW+1)'(FIFO_DEPTH)) begin
               issue = 1'b1;
               k_d = k_q + 2'd1;
               if (k_q == 2'd3) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head.idx == 2'd3) begin
               o_wire_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Corner k walks the quad counter-clockwise starting bottom-left.
   always_comb begin
      rot_x_in = (k_q == 2'd0 || k_q == 2'd3) ? -hw_q : hw_q;
      rot_y_in = (k_q < 2'd2) ? -hh_q : hh_q;
      tag_v_d[0]   = issue;
      tag_idx_d[0] = k_q;
      for (int i = 1; i < ROTATE_LATENCY; i++) begin
         tag_v_d[i]   = tag_v_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end
      sum_v_d   = tag_v_q[ROTATE_LATENCY-1];
      sum_d.x   = rot_x + cx_q;
      sum_d.y   = rot_y + cy_q;
      sum_d.idx = tag_idx_q[ROTATE_LATENCY-1];
      inflight_d = inflight_q;
      case ({issue, push})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = sum_q;
         wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   assign o_wire_point_x    = o_wire_point_valid ? head.x : '0;
   assign o_wire_point_y    = o_wire_point_valid ? head.y : '0;
   assign o_wire_point_idx  = o_wire_point_valid ? head.idx : '0;
   assign o_wire_point_last = o_wire_point_valid && (head.idx == 2'd3);

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q <= IDLE;
         cx_q <= '0; cy_q <= '0; hw_q <= '0; hh_q <= '0; ang_q <= '0;
         k_q <= '0;
         tag_v_q <= '0;
         for (int i = 0; i < ROTATE_LATENCY; i++) tag_idx_q[i] <= '0;
         inflight_q <= '0;
         sum_v_q <= 1'b0;
         sum_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cx_q <= cx_d; cy_q <= cy_d; hw_q <= hw_d; hh_q <= hh_d; ang_q <= ang_d;
         k_q <= k_d;
         tag_v_q <= tag_v_d;
         tag_idx_q <= tag_idx_d;
         inflight_q <= inflight_d;
         sum_v_q <= sum_v_d;
         sum_q <= sum_d;
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end

`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
   logic signed [31:0] xmin_q, xmin_d, ymin_q, ymin_d, xmax_q, xmax_d, ymax_q, ymax_d;

   // Corner 0 seeds the box; later corners widen it as they enter the FIFO.
   always_comb begin
      xmin_d = xmin_q; ymin_d = ymin_q; xmax_d = xmax_q; ymax_d = ymax_q;
      if (push) begin
         if (sum_q.idx == 2'd0) begin
            xmin_d = sum_q.x; xmax_d = sum_q.x;
            ymin_d = sum_q.y; ymax_d = sum_q.y;
         end else begin
            if ($signed(sum_q.x) < xmin_q) xmin_d = sum_q.x;
            if ($signed(sum_q.x) > xmax_q) xmax_d = sum_q.x;
            if ($signed(sum_q.y) < ymin_q) ymin_d = sum_q.y;
            if ($signed(sum_q.y) > ymax_q) ymax_d = sum_q.y;
         end
      end
   end

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         xmin_q <= '0; ymin_q <= '0; xmax_q <= '0; ymax_q <= '0;
      end else begin
         xmin_q <= xmin_d; ymin_q <= ymin_d; xmax_q <= xmax_d; ymax_q <= ymax_d;
      end
   end

   assign o_wire_bbox_xmin = xmin_q;
   assign o_wire_bbox_ymin = ymin_q;
   assign o_wire_bbox_xmax = xmax_q;
   assign o_wire_bbox_ymax = ymax_q;
`endif
endmodule

// File: tb/tb_painterengine_gpu_rotate_ctrl.sv
// Directed bench for painterengine_gpu_rotate_ctrl: default depth instance plus a depth-2 instance for backpressure.
module tb_painterengine_gpu_rotate_ctrl;
   logic        clk, rst;
   logic        job_valid, job_ready, job_valid2, job_ready2;
   logic [31:0] cx, cy, hw, hh, angle;
   logic        pv, pr, plast, done, pv2, pr2, plast2, done2;
   logic [31:0] px, py, px2, py2;
   logic [1:0]  pidx, pidx2;
`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
   logic [31:0] bxmin, bymin, bxmax, bymax, b2xmin, b2ymin, b2xmax, b2ymax;
`endif

   int total = 0;
   int bad   = 0;
   int got_x [8];
   int got_y [8];
   int got_idx [8];
   int got_last [8];
   int n_got, done_cnt, first_valid, stale, issues, max_used, used;

   int a0x [4] = '{5898240, 7208960, 7208960, 5898240};
   int a0y [4] = '{2949120, 2949120, 3604480, 3604480};
   int a90x [4] = '{6881280, 6881280, 6225920, 6225920};
   int a90y [4] = '{2621440, 3932160, 3932160, 2621440};

   painterengine_gpu_rotate_ctrl dut (
      .i_wire_clock(clk), .i_wire_reset(rst),
      .i_wire_job_valid(job_valid), .o_wire_job_ready(job_ready),
      .i_wire_cx(cx), .i_wire_cy(cy), .i_wire_hw(hw), .i_wire_hh(hh), .i_wire_angle(angle),
      .o_wire_point_valid(pv), .i_wire_point_ready(pr),
      .o_wire_point_x(px), .o_wire_point_y(py), .o_wire_point_idx(pidx),
      .o_wire_point_last(plast), .o_wire_done(done)
`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
      , .o_wire_bbox_xmin(bxmin), .o_wire_bbox_ymin(bymin),
      .o_wire_bbox_xmax(bxmax), .o_wire_bbox_ymax(bymax)
`endif
   );

   painterengine_gpu_rotate_ctrl #(.ROTATE_LATENCY(22), .FIFO_DEPTH(2)) dut2 (
      .i_wire_clock(clk), .i_wire_reset(rst),
      .i_wire_job_valid(job_valid2), .o_wire_job_ready(job_ready2),
      .i_wire_cx(cx), .i_wire_cy(cy), .i_wire_hw(hw), .i_wire_hh(hh), .i_wire_angle(angle),
      .o_wire_point_valid(pv2), .i_wire_point_ready(pr2),
      .o_wire_point_x(px2), .o_wire_point_y(py2), .o_wire_point_idx(pidx2),
      .o_wire_point_last(plast2), .o_wire_done(done2)
`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
      , .o_wire_bbox_xmin(b2xmin), .o_wire_bbox_ymin(b2ymin),
      .o_wire_bbox_xmax(b2xmax), .o_wire_bbox_ymax(b2ymax)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkNear(input string tag, input int observed, input int expected);
      longint d;
      d = longint'(observed) - longint'(expected);
      total++;
      assert (d <= 64 && d >= -64)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d (+-64)", tag, observed, expected);
      end
   endtask

   // Offers one job to the default instance and records every popped corner.
   task automatic applyStimulus(input logic [31:0] jcx, input logic [31:0] jcy,
                                input logic [31:0] jhw, input logic [31:0] jhh,
                                input logic [31:0] jang, input int cycles);
      cx = jcx; cy = jcy; hw = jhw; hh = jhh; angle = jang;
      pr = 1'b1;
      job_valid = 1'b1;
      n_got = 0; done_cnt = 0; first_valid = -1;
      @(posedge clk); #1;
      job_valid = 1'b0;
      for (int n = 1; n <= cycles; n++) begin
         if (pv && first_valid < 0) first_valid = n;
         if (pv && pr && n_got < 8) begin
            got_x[n_got] = px; got_y[n_got] = py;
            got_idx[n_got] = int'(pidx); got_last[n_got] = int'(plast);
            n_got++;
         end
         if (done) done_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic checkPoints(input string pfx, input int ex [4], input int ey [4]);
      checkOutput({pfx, "_count"}, n_got, 4);
      checkOutput({pfx, "_done"}, done_cnt, 1);
      for (int k = 0; k < 4; k++) begin
         checkNear($sformatf("%s_x%0d", pfx, k), got_x[k], ex[k]);
         checkNear($sformatf("%s_y%0d", pfx, k), got_y[k], ey[k]);
         checkOutput($sformatf("%s_idx%0d", pfx, k), got_idx[k], k);
         checkOutput($sformatf("%s_last%0d", pfx, k), got_last[k], (k == 3) ? 1 : 0);
      end
   endtask

   initial begin
      rst = 1'b1; job_valid = 1'b0; job_valid2 = 1'b0; pr = 1'b0; pr2 = 1'b0;
      cx = '0; cy = '0; hw = '0; hh = '0; angle = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_job_ready", job_ready, 1);
      checkOutput("rst_point_valid", pv, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_x", px, 0);
      checkOutput("rst_y", py, 0);
      checkOutput("rst_idx", pidx, 0);
      checkOutput("rst_last", plast, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] angle 0 job");
      applyStimulus(32'd6553600, 32'd3276800, 32'd655360, 32'd327680, 32'd0, 40);
      checkOutput("a0_latency", first_valid, 25);
      checkPoints("a0", a0x, a0y);
      checkOutput("a0_ready_after", job_ready, 1);

      $display("[TB] angle 90 job");
      applyStimulus(32'd6553600, 32'd3276800, 32'd655360, 32'd327680, 32'd5898240, 40);
      checkOutput("a90_latency", first_valid, 25);
      checkPoints("a90", a90x, a90y);

      $display("[TB] reset mid-job");
      cx = 32'd6553600; cy = 32'd3276800; hw = 32'd655360; hh = 32'd327680; angle = 32'd0;
      job_valid = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0;
      checkOutput("mid_busy", job_ready, 0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("mid_point_valid", pv, 0);
      checkOutput("mid_job_ready", job_ready, 1);
      checkOutput("mid_done", done, 0);
      stale = 0; done_cnt = 0;
      repeat (40) begin
         if (pv) stale++;
         if (done) done_cnt++;
         @(posedge clk); #1;
      end
      checkOutput("mid_stale", stale, 0);
      checkOutput("mid_no_done", done_cnt, 0);
      applyStimulus(32'd6553600, 32'd3276800, 32'd655360, 32'd327680, 32'd0, 40);
      checkPoints("post", a0x, a0y);

      $display("[TB] backpressure depth 2");
      cx = 32'd6553600; cy = 32'd3276800; hw = 32'd655360; hh = 32'd327680; angle = 32'd0;
      pr2 = 1'b0;
      job_valid2 = 1'b1;
      @(posedge clk); #1;
      job_valid2 = 1'b0;
      issues = 0; max_used = 0;
      repeat (60) begin
         if (dut2.issue) issues++;
         used = int'(dut2.inflight_q) + int'(dut2.count_q);
         if (used > max_used) max_used = used;
         @(posedge clk); #1;
      end
      checkOutput("bp_issues", issues, 2);
      checkOutput("bp_max_used", max_used, 2);
      checkOutput("bp_head_valid", pv2, 1);
      checkOutput("bp_head_idx", pidx2, 0);
      checkNear("bp_head_x", px2, a0x[0]);
      pr2 = 1'b1;
      n_got = 0; done_cnt = 0;
      for (int n = 0; n < 150; n++) begin
         if (pv2 && pr2 && n_got < 8) begin
            got_x[n_got] = px2; got_y[n_got] = py2;
            got_idx[n_got] = int'(pidx2); got_last[n_got] = int'(plast2);
            n_got++;
         end
         if (done2) done_cnt++;
         used = int'(dut2.inflight_q) + int'(dut2.count_q);
         if (used > max_used) max_used = used;
         @(posedge clk); #1;
      end
      checkPoints("bp", a0x, a0y);
      checkOutput("bp_max_used_total", max_used, 2);

`ifdef PAINTERENGINE_GPU_ROTATE_CTRL_BBOX_EN
      $display("[TB] bbox at 45 degrees");
      applyStimulus(32'd0, 32'd0, 32'd65536, 32'd65536, 32'd2949120, 40);
      checkOutput("bb_done", done_cnt, 1);
      checkNear("bb_xmin", bxmin, -92682);
      checkNear("bb_ymin", bymin, -92682);
      checkNear("bb_xmax", bxmax, 92682);
      checkNear("bb_ymax", bymax, 92682);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
